stream_buffer_prefetch: RTL and testbench

Multi-line successor to the single-line stream buffer in the cache utilities. It holds DEPTH consecutive cache lines fetched over AXI3 read bursts and serves line requests, keyed by label (tag + index), from the FIFO head. Sequential misses are therefore absorbed without a full memory round trip. It sits between a cache miss handler and the AXI3 read channel.

---
 rtl/stream_buffer_prefetch_pkg.sv | 40 ++++
 rtl/stream_buffer_prefetch_if.sv | 30 +++
 rtl/stream_line_fifo.sv | 66 ++++++
 rtl/stream_buffer_prefetch.sv | 180 ++++++++++++++++++
 tb/tb_stream_buffer_prefetch.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/stream_buffer_prefetch_pkg.sv
// Shared cache types and AXI constants for the multi-line stream buffer.
// Provides the physical address type, line/label types, the beat count helper,
// the AXI burst/size encodings and the fetch FSM state encoding.
package stream_buffer_prefetch_pkg;

  localparam int PHYS_WIDTH = 32;
  typedef logic [PHYS_WIDTH-1:0] phys_t;

  localparam int LINE_WIDTH_DEF = 256;
  localparam int BUS_WIDTH_DEF  = 4;
  localparam int DEPTH_DEF      = 4;
  localparam int ARID_DEF       = 2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int beats_f(input int line_w, input int bus_w);
    return line_w / (bus_w * 8);
  endfunction

  // Label = physical address with the in-line byte offset stripped.
  function automatic int label_width_f(input int line_w);
    return $bits(phys_t) - $clog2(line_w / 8);
  endfunction

  function automatic logic [2:0] axi_size_f(input int bus_w);
    return 3'($clog2(bus_w));
  endfunction

  localparam int LABEL_WIDTH_DEF = label_width_f(LINE_WIDTH_DEF);
  typedef logic [LINE_WIDTH_DEF-1:0]  line_t;
  typedef logic [LABEL_WIDTH_DEF-1:0] label_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_R     = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/stream_buffer_prefetch_if.sv
// AXI3 read address + read data channels used by the stream buffer.
// Ports: ar* (address channel, master drives), r* (data channel, slave drives).
// Master = stream buffer, slave = memory side.
interface stream_buffer_prefetch_if
  import stream_buffer_prefetch_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
);
  logic [3:0]             arid;
  phys_t                  araddr;
  logic [3:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;
  logic [BUS_WIDTH*8-1:0] rdata;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/stream_line_fifo.sv
// DEPTH-entry FIFO of {label, line}; push/pop/flush, head outputs, full/empty.
// Ports: push_* (tail write), pop_i (head advance), flush_i (drop all), head_*_o, full_o, empty_o.
// Pointers carry one extra wrap bit so full/empty fall out of an MSB compare.
module stream_line_fifo #(
  parameter int LABEL_WIDTH = 27,
  parameter int LINE_WIDTH  = 256,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [LABEL_WIDTH-1:0] push_label_i,
  input  logic [LINE_WIDTH-1:0]  push_line_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [LABEL_WIDTH-1:0] head_label_o,
  output logic [LINE_WIDTH-1:0]  head_line_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LABEL_WIDTH-1:0] label_mem [DEPTH];
  logic [LINE_WIDTH-1:0]  line_mem  [DEPTH];
  logic                   do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

  // A push into a full FIFO is accepted when the head pops in the same cycle.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      rptr_d = wptr_q;
    end else begin
      if (do_push) wptr_d = wptr_q + (PW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      label_mem[wptr_q[PW-1:0]] <= push_label_i;
      line_mem[wptr_q[PW-1:0]]  <= push_line_i;
    end
  end

  assign head_label_o = label_mem[rptr_q[PW-1:0]];
  assign head_line_o  = line_mem[rptr_q[PW-1:0]];
endmodule

// File: rtl/stream_buffer_prefetch.sv
// Multi-line stream buffer: prefetches consecutive lines over AXI3 and serves label requests from the FIFO head.
// Ports: addr/addr_rdy (request), label/data/data_vld (one-cycle response), axi3_rd_if (AXI3 read master).
// Hit answers next cycle; a miss flushes, refetches from addr and answers when that line commits.
module stream_buffer_prefetch
  import stream_buffer_prefetch_pkg::*;
#(
  parameter int  LINE_WIDTH  = LINE_WIDTH_DEF,
  parameter int  BUS_WIDTH   = BUS_WIDTH_DEF,
  parameter int  DEPTH       = DEPTH_DEF,
  parameter int  ARID        = ARID_DEF,
  localparam int LABEL_WIDTH = label_width_f(LINE_WIDTH),
  localparam int BEATS       = beats_f(LINE_WIDTH, BUS_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LABEL_WIDTH-1:0] addr,
  input  logic                   addr_rdy,
  output logic [LABEL_WIDTH-1:0] label,
  output logic [LINE_WIDTH-1:0]  data,
  output logic                   data_vld,
  stream_buffer_prefetch_if.master axi3_rd_if
);
  localparam int BW     = BUS_WIDTH * 8;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  fetch_state_t           state_q, state_d;
  logic [LABEL_WIDTH-1:0] fetch_label_q, fetch_label_d, burst_label_q, burst_label_d;
  logic [LABEL_WIDTH-1:0] pend_label_q, pend_label_d, label_q, label_d;
  logic                   fetch_vld_q, fetch_vld_d, pend_vld_q, pend_vld_d;
  logic                   data_vld_q, data_vld_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [LINE_WIDTH-1:0]  acc_q, acc_d, data_q, data_d, line_fill;

  logic                   fifo_full, fifo_empty, fifo_push;
  logic [LABEL_WIDTH-1:0] fifo_head_label;
  logic [LINE_WIDTH-1:0]  fifo_head_line;

  logic                   hit, miss, keep, commit, serve, pend_vld_eff, ar_hs, beat_xfer;
  logic [LABEL_WIDTH-1:0] tgt_label, pend_label_eff;

  // Request decode. tgt_label is the label the fetch stream should be on after this cycle.
  assign hit            = addr_rdy && !fifo_empty && (fifo_head_label == addr);
  assign miss           = addr_rdy && !hit;
  assign tgt_label      = miss ? addr : fetch_label_q;
  assign pend_vld_eff   = miss || (pend_vld_q && !hit);
  assign pend_label_eff = miss ? addr : pend_label_q;

  // The burst in flight is only worth keeping while it matches where the stream is headed.
  assign keep      = (burst_label_q == tgt_label);
  assign ar_hs     = (state_q == ST_AR) && axi3_rd_if.arready;
  assign beat_xfer = ((state_q == ST_R) || (state_q == ST_DRAIN)) && axi3_rd_if.rvalid;
  assign commit    = (state_q == ST_R) && axi3_rd_if.rvalid && axi3_rd_if.rlast && keep;
  assign serve     = commit && pend_vld_eff && (burst_label_q == pend_label_eff);
  assign fifo_push = commit && !serve;

  // Tail line with the current beat merged in, so a commit sees the full line.
  always_comb begin
    line_fill = acc_q;
    line_fill[int'(beat_q)*BW +: BW] = axi3_rd_if.rdata;
  end

  stream_line_fifo #(
    .LABEL_WIDTH(LABEL_WIDTH),
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_label_i(burst_label_q),
    .push_line_i (line_fill),
    .pop_i       (hit),
    .flush_i     (miss),
    .head_label_o(fifo_head_label),
    .head_line_o (fifo_head_line),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. IDLE holds off while a request is being taken so the AR
  // is always issued from the settled fetch label.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fetch_vld_q && !fifo_full && !addr_rdy) state_d = ST_AR;
      ST_AR:    if (axi3_rd_if.arready) state_d = keep ? ST_R : ST_DRAIN;
      ST_R: begin
        if (axi3_rd_if.rvalid && axi3_rd_if.rlast) state_d = ST_IDLE;
        else if (!keep)                            state_d = ST_DRAIN;
      end
      ST_DRAIN: if (axi3_rd_if.rvalid && axi3_rd_if.rlast) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    axi3_rd_if.arvalid = 1'b0;
    axi3_rd_if.rready  = 1'b0;
    unique case (state_q)
      ST_AR:          axi3_rd_if.arvalid = 1'b1;
      ST_R, ST_DRAIN: axi3_rd_if.rready  = 1'b1;
      default: ;
    endcase
  end

  assign axi3_rd_if.arid    = 4'(ARID);
  assign axi3_rd_if.arlen   = 4'(BEATS - 1);
  assign axi3_rd_if.arsize  = axi_size_f(BUS_WIDTH);
  assign axi3_rd_if.arburst = AXI_BURST_INCR;
  assign axi3_rd_if.araddr  = {burst_label_q, {OFF_W{1'b0}}};

  always_comb begin
    fetch_label_d = fetch_label_q;
    if (commit)    fetch_label_d = burst_label_q + LABEL_WIDTH'(1);
    else if (miss) fetch_label_d = addr;
    fetch_vld_d   = fetch_vld_q || addr_rdy;
    // Burst label tracks the fetch pointer while idle and freezes once AR is raised.
    burst_label_d = (state_q == ST_IDLE) ? fetch_label_q : burst_label_q;
    pend_vld_d    = pend_vld_eff && !serve;
    pend_label_d  = pend_label_eff;
    beat_d        = beat_q;
    acc_d         = acc_q;
    if (ar_hs) begin
      beat_d = '0;
    end else if (beat_xfer) begin
      beat_d = beat_q + BEAT_W'(1);
      acc_d  = line_fill;
    end
    data_vld_d = 1'b0;
    label_d    = label_q;
    data_d     = data_q;
    if (hit) begin
      data_vld_d = 1'b1;
      label_d    = fifo_head_label;
      data_d     = fifo_head_line;
    end else if (serve) begin
      data_vld_d = 1'b1;
      label_d    = burst_label_q;
      data_d     = line_fill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_label_q <= '0;
      fetch_vld_q   <= 1'b0;
      burst_label_q <= '0;
      pend_vld_q    <= 1'b0;
      pend_label_q  <= '0;
      beat_q        <= '0;
      acc_q         <= '0;
      data_vld_q    <= 1'b0;
      label_q       <= '0;
      data_q        <= '0;
    end else begin
      fetch_label_q <= fetch_label_d;
      fetch_vld_q   <= fetch_vld_d;
      burst_label_q <= burst_label_d;
      pend_vld_q    <= pend_vld_d;
      pend_label_q  <= pend_label_d;
      beat_q        <= beat_d;
      acc_q         <= acc_d;
      data_vld_q    <= data_vld_d;
      label_q       <= label_d;
      data_q        <= data_d;
    end
  end

  assign data_vld = data_vld_q;
  assign label    = label_q;
  assign data     = data_q;
endmodule

// File: tb/tb_stream_buffer_prefetch.sv
// Bench for stream_buffer_prefetch: AXI3 memory model returning word index as data,
// table of directed requests plus hand sequences for supersede, wrap and mid-burst reset.
// Slave keeps arready/rvalid high so latencies are exact.
module tb_stream_buffer_prefetch;
  import stream_buffer_prefetch_pkg::*;

  localparam int BEATS = beats_f(LINE_WIDTH_DEF, BUS_WIDTH_DEF);

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  label_t addr = '0;
  logic   addr_rdy = 1'b0;
  label_t label;
  line_t  data;
  logic   data_vld;

  stream_buffer_prefetch_if #(.BUS_WIDTH(BUS_WIDTH_DEF)) bus ();

  stream_buffer_prefetch #(
    .LINE_WIDTH(LINE_WIDTH_DEF),
    .BUS_WIDTH (BUS_WIDTH_DEF),
    .DEPTH     (4),
    .ARID      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .addr_rdy  (addr_rdy),
    .label     (label),
    .data      (data),
    .data_vld  (data_vld),
    .axi3_rd_if(bus)
  );

  always #5 clk = ~clk;

  // Memory slave: word at byte address A holds A/4.
  logic       busy_q;
  phys_t      word_q;
  logic [3:0] sbeat_q;
  phys_t      ar_log[$];

  assign bus.arready = 1'b1;
  assign bus.rvalid  = busy_q;
  assign bus.rdata   = word_q + 32'(sbeat_q);
  assign bus.rlast   = busy_q && (int'(sbeat_q) == BEATS - 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      sbeat_q <= '0;
      word_q  <= '0;
      ar_log.delete();
    end else begin
      if (bus.arvalid && bus.arready) begin
        ar_log.push_back(bus.araddr);
        word_q  <= bus.araddr >> 2;
        sbeat_q <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q && bus.rready) begin
        sbeat_q <= sbeat_q + 4'd1;
        if (int'(sbeat_q) == BEATS - 1) busy_q <= 1'b0;
      end
    end
  end

  int vld_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (data_vld) vld_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic line_t exp_line(input label_t l);
    line_t v;
    phys_t w;
    w = {l, 5'b0} >> 2;
    for (int i = 0; i < BEATS; i++) v[i*32 +: 32] = w + 32'(i);
    return v;
  endfunction

  task automatic send(input label_t a);
    @(negedge clk);
    addr     = a;
    addr_rdy = 1'b1;
    @(negedge clk);
    addr_rdy = 1'b0;
  endtask

  // Returns at the negedge where data_vld is seen; lat counts cycles after the request edge.
  task automatic wait_vld(output int lat);
    lat = 1;
    while (!data_vld && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("vld_seen", data_vld, 1'b1);
  endtask

  typedef struct {
    label_t a;
    int     gap;
    int     ars;
    int     lat;
    label_t exp_label;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int n0;
    int n;
    int guard;

    // gap = idle cycles before the request, ars = AR count expected just before it (-1 skip)
    vecs[0] = '{a: 27'h10, gap: 2,  ars: 0,  lat: 11, exp_label: 27'h10};
    vecs[1] = '{a: 27'h11, gap: 50, ars: 5,  lat: 1,  exp_label: 27'h11};
    vecs[2] = '{a: 27'h12, gap: 0,  ars: -1, lat: 1,  exp_label: 27'h12};
    vecs[3] = '{a: 27'h13, gap: 0,  ars: -1, lat: 1,  exp_label: 27'h13};
    vecs[4] = '{a: 27'h40, gap: 0,  ars: 6,  lat: 15, exp_label: 27'h40};

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_vld", data_vld, 1'b0);
    chk("rst_label", label, '0);
    chk("rst_data", data, '0);
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_rready", bus.rready, 1'b0);
    rst = 1'b0;
    chk("arid", bus.arid, 2);
    chk("arlen", bus.arlen, 7);
    chk("arsize", bus.arsize, 2);
    chk("arburst", bus.arburst, 1);

    for (int i = 0; i < 5; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      if (vecs[i].ars >= 0) chk("ar_count_before", ar_log.size(), vecs[i].ars);
      n0 = vld_cnt;
      send(vecs[i].a);
      wait_vld(lat);
      chk("latency", lat, vecs[i].lat);
      chk("label", label, vecs[i].exp_label);
      chk("data", data, exp_line(vecs[i].exp_label));
      chk("vld_pulses", vld_cnt - n0, 1);
    end
    chk("ar_prefetch_0x14", ar_log[4], {27'h14, 5'b0});
    chk("ar_after_pop_0x15", ar_log[5], {27'h15, 5'b0});
    chk("ar_after_flush_0x40", ar_log[6], {27'h40, 5'b0});

    // Superseding request: only the newest is answered.
    repeat (60) @(negedge clk);
    n0 = vld_cnt;
    send(27'h20);
    send(27'h30);
    wait_vld(lat);
    chk("supersede_label", label, 27'h30);
    chk("supersede_data", data, exp_line(27'h30));
    repeat (60) @(negedge clk);
    chk("supersede_pulses", vld_cnt - n0, 1);

    // Label wrap: after all-ones the prefetch continues at label 0.
    n = ar_log.size();
    send(27'h7FFFFFF);
    wait_vld(lat);
    chk("wrap_label", label, 27'h7FFFFFF);
    chk("wrap_data", data, exp_line(27'h7FFFFFF));
    guard = 0;
    while (ar_log.size() < n + 2 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("wrap_ar_seen", ar_log.size() >= n + 2, 1'b1);
    chk("wrap_ar_top", ar_log[n], 32'hFFFF_FFE0);
    chk("wrap_ar_zero", ar_log[n+1], 32'h0);

    // Reset in the middle of a burst.
    repeat (60) @(negedge clk);
    send(27'h50);
    repeat (4) @(negedge clk);
    chk("midburst_rready", bus.rready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data_vld", data_vld, 1'b0);
    chk("arst_label", label, '0);
    chk("arst_data", data, '0);
    chk("arst_arvalid", bus.arvalid, 1'b0);
    chk("arst_rready", bus.rready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(27'h10);
    wait_vld(lat);
    chk("post_rst_latency", lat, 11);
    chk("post_rst_label", label, 27'h10);
    chk("post_rst_data", data, exp_line(27'h10));
    chk("post_rst_first_ar", ar_log[0], {27'h10, 5'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
